// File: rtl/seq_run_ctrl.sv
// seq_run_ctrl: shares one serial recognizer core between two requesters, streaming
// each granted word into the core LSB first and returning the captured t1/t2 words.
module seq_run_ctrl #(
  parameter int W  = 8,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          res,
  input  logic          req0,
  input  logic          req1,
  input  logic [W-1:0]  data0,
  input  logic [W-1:0]  data1,
  input  logic [LW-1:0] len0,
  input  logic [LW-1:0] len1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [W-1:0]  t1_word,
  output logic [W-1:0]  t2_word,
  output logic          busy,
  output logic          core_res,
  output logic          core_x,
  input  logic          core_t1,
  input  logic          core_t2
);

  // state | meaning
  // IDLE  | no job; requests are arbitrated here
  // CLR   | grant pulse, core clear, result words cleared
  // RUN   | one input bit fed and one response bit captured per cycle
  // DONE  | done pulse, last-served pointer moves to the owner
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CLR  = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state;
  logic          owner;
  logic          last;
  logic [W-1:0]  data_sr;
  logic [W-1:0]  bit_mask;
  logic [LW-1:0] rem;

  logic          pick1;
  logic [W-1:0]  pick_data;
  logic [LW-1:0] pick_len;

  // On a tie the requester that was not served last wins.
  always_comb begin
    pick1     = (req0 && req1) ? ~last : req1;
    pick_data = pick1 ? data1 : data0;
    pick_len  = pick1 ? len1 : len0;
    if (pick_len > LW'(W))
      pick_len = LW'(W);
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      data_sr  <= '0;
      bit_mask <= '0;
      rem      <= '0;
      t1_word  <= '0;
      t2_word  <= '0;
      core_res <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner    <= pick1;
            data_sr  <= pick_data;
            rem      <= pick_len;
            core_res <= 1'b1;
            state    <= CLR;
          end
        end
        CLR: begin
          t1_word  <= '0;
          t2_word  <= '0;
          bit_mask <= W'(1);
          core_res <= 1'b0;
          state    <= (rem == '0) ? DONE : RUN;
        end
        RUN: begin
          // rem counts the bits still to run; bit_mask marks the bit being captured.
          t1_word  <= t1_word | (bit_mask & {W{core_t1}});
          t2_word  <= t2_word | (bit_mask & {W{core_t2}});
          data_sr  <= data_sr >> 1;
          bit_mask <= bit_mask << 1;
          rem      <= rem - LW'(1);
          if (rem == LW'(1))
            state <= DONE;
        end
        DONE: begin
          last  <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign gnt0   = (state == CLR) && !owner;
  assign gnt1   = (state == CLR) && owner;
  assign done0  = (state == DONE) && !owner;
  assign done1  = (state == DONE) && owner;
  assign core_x = (state == RUN) && data_sr[0];

endmodule

// File: tb/tb_seq_run_ctrl.sv
// Bench for seq_run_ctrl: job-level reference model checked every cycle, plus
// directed jobs with hand-computed results and a randomized two-requester phase.
module tb_seq_run_ctrl;
  localparam int W  = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          res;
  logic          req0, req1;
  logic [W-1:0]  data0, data1;
  logic [LW-1:0] len0, len1;
  logic          gnt0, gnt1, done0, done1;
  logic [W-1:0]  t1_word, t2_word;
  logic          busy, core_res, core_x, core_t1, core_t2;
  logic          use_real = 1'b0;
  logic          core_prev;

  int n_chk = 0, n_pass = 0;
  int n_res = 0, n_jobs = 0, n_done = 0;

  always #5 clk = ~clk;

  seq_run_ctrl #(.W(W), .LW(LW)) dut (
    .clk(clk), .res(res),
    .req0(req0), .req1(req1), .data0(data0), .data1(data1), .len0(len0), .len1(len1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .t1_word(t1_word), .t2_word(t2_word), .busy(busy),
    .core_res(core_res), .core_x(core_x), .core_t1(core_t1), .core_t2(core_t2)
  );

  // Stub core (t1 = x, t2 = ~x) or recognizer stand-in: t1 flags "11", t2 flags "10".
  always @(posedge clk or posedge res) begin
    if (res) core_prev <= 1'b0;
    else     core_prev <= core_res ? 1'b0 : core_x;
  end
  assign core_t1 = use_real ? (core_prev & core_x)  : core_x;
  assign core_t2 = use_real ? (core_prev & ~core_x) : ~core_x;

  // Job-level model: offset k within the current job (0 = grant cycle).
  bit           m_act, m_own, m_last;
  int           m_k, m_len;
  logic [W-1:0] m_data, m_t1, m_t2;

  function automatic logic [2*W-1:0] expect_words(logic [W-1:0] d, int n, logic r);
    logic [W-1:0] m, a, b;
    m = (n >= W) ? '1 : W'((1 << n) - 1);
    if (r) begin
      a = d & (d << 1) & m;
      b = ~d & (d << 1) & m;
    end else begin
      a = d & m;
      b = ~d & m;
    end
    return {a, b};
  endfunction

  task automatic model_reset();
    m_act = 0; m_own = 0; m_last = 1; m_k = 0; m_len = 0;
    m_data = '0; m_t1 = '0; m_t2 = '0;
  endtask

  task automatic model_edge();
    if (m_act) begin
      if (m_k == m_len + 1) begin
        m_act  = 0;
        m_last = m_own;
        {m_t1, m_t2} = expect_words(m_data, m_len, use_real);
      end else begin
        m_k++;
      end
    end else if (req0 || req1) begin
      m_own  = (req0 && req1) ? !m_last : req1;
      m_data = m_own ? data1 : data0;
      m_len  = m_own ? int'(len1) : int'(len0);
      if (m_len > W) m_len = W;
      m_act  = 1;
      m_k    = 0;
      n_jobs++;
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
  endtask

  task automatic chkw(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  task automatic chki(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
  endtask

  task automatic compare_all();
    logic e_g, e_d, e_x;
    logic [W-1:0] e1, e2;
    int n;
    e_g = m_act && (m_k == 0);
    e_d = m_act && (m_k == m_len + 1);
    e_x = 1'b0;
    if (m_act && m_k >= 1 && m_k <= m_len) e_x = m_data[m_k-1];
    if (m_act && m_k >= 1) begin
      n = (m_k - 1 < m_len) ? m_k - 1 : m_len;
      {e1, e2} = expect_words(m_data, n, use_real);
    end else begin
      e1 = m_t1; e2 = m_t2;
    end
    chk1("gnt0", gnt0, e_g && !m_own);
    chk1("gnt1", gnt1, e_g && m_own);
    chk1("done0", done0, e_d && !m_own);
    chk1("done1", done1, e_d && m_own);
    chk1("busy", busy, m_act);
    chk1("core_res", core_res, e_g);
    chk1("core_x", core_x, e_x);
    chkw("t1_word", t1_word, e1);
    chkw("t2_word", t2_word, e2);
    if (core_res === 1'b1) n_res++;
    if (done0 === 1'b1 || done1 === 1'b1) n_done++;
  endtask

  task automatic step();
    @(posedge clk);
    if (!res) model_edge();
    #1 compare_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    req0 = 0; req1 = 0; res = 1;
    #1 model_reset();
    compare_all();
    step();
    step();
    res = 0;
  endtask

  task automatic drain();
    req0 = 0; req1 = 0;
    for (int c = 0; c < 40 && busy; c++) step();
    chk1("drain_idle", busy, 1'b0);
  endtask

  task automatic job(input logic who, input logic [W-1:0] d, input logic [LW-1:0] l,
                     output int g2d, output int busy_n, output int run_n, output int x_n);
    int g_at;
    g_at = -1; g2d = -1; busy_n = 0; run_n = 0; x_n = 0;
    if (who) begin data1 = d; len1 = l; req1 = 1'b1; end
    else     begin data0 = d; len0 = l; req0 = 1'b1; end
    for (int c = 0; c < 40 && g2d < 0; c++) begin
      step();
      if (busy) busy_n++;
      if (busy && !core_res && !done0 && !done1) run_n++;
      if (core_x) x_n++;
      if (who ? gnt1 : gnt0) begin
        g_at = c;
        if (who) req1 = 1'b0; else req0 = 1'b0;
      end
      if (g_at >= 0 && (who ? done1 : done0)) g2d = c - g_at;
    end
    step();
  endtask

  task automatic random_phase(int ncyc);
    bit p0, p1;
    p0 = 0; p1 = 0;
    for (int c = 0; c < ncyc; c++) begin
      step();
      if (p0) begin
        if (gnt0 || $urandom_range(0, 29) == 0) p0 = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        p0 = 1; data0 = W'($urandom); len0 = LW'($urandom_range(0, 15));
      end
      if (p1) begin
        if (gnt1 || $urandom_range(0, 29) == 0) p1 = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        p1 = 1; data1 = W'($urandom); len1 = LW'($urandom_range(0, 15));
      end
      req0 = p0; req1 = p1;
    end
    drain();
  endtask

  initial begin
    int g2d, bn, rn, xn, ng, dbl, d0, r0;
    int gseq [4];
    data0 = '0; data1 = '0; len0 = '0; len1 = '0;
    do_reset();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_core_res", core_res, 1'b0);
    chkw("rst_t1", t1_word, 8'h00);

    job(1'b0, 8'hA5, 4'd8, g2d, bn, rn, xn);
    chki("a5_gnt_to_done", g2d, 9);
    chki("a5_busy_cycles", bn, 10);
    chkw("a5_t1", t1_word, 8'hA5);
    chkw("a5_t2", t2_word, 8'h5A);

    job(1'b1, 8'hFF, 4'd3, g2d, bn, rn, xn);
    chki("len3_gnt_to_done", g2d, 4);
    chkw("len3_t1", t1_word, 8'h07);
    chkw("len3_t2", t2_word, 8'h00);

    job(1'b1, 8'hFF, 4'd12, g2d, bn, rn, xn);
    chki("clamp_run_cycles", rn, 8);
    chkw("clamp_t1", t1_word, 8'hFF);
    chkw("clamp_t2", t2_word, 8'h00);

    job(1'b0, 8'h3C, 4'd0, g2d, bn, rn, xn);
    chki("empty_gnt_to_done", g2d, 1);
    chki("empty_core_x_high", xn, 0);
    chkw("empty_t1", t1_word, 8'h00);
    chkw("empty_t2", t2_word, 8'h00);

    do_reset();
    req0 = 1; req1 = 1; data0 = W'($urandom); data1 = W'($urandom); len0 = 4'd2; len1 = 4'd3;
    ng = 0; dbl = 0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      step();
      if (gnt0 && gnt1) dbl++;
      if (done0 && done1) dbl++;
      if (gnt0) begin gseq[ng] = 0; ng++; end
      else if (gnt1) begin gseq[ng] = 1; ng++; end
    end
    drain();
    chki("rr_grants", ng, 4);
    for (int i = 0; i < 4; i++) chki("rr_order", (i < ng) ? gseq[i] : -1, i % 2);
    chki("rr_double_pulse", dbl, 0);

    req0 = 1; data0 = 8'hFF; len0 = 4'd8;
    step();
    chk1("mr_gnt0", gnt0, 1'b1);
    req0 = 0;
    for (int i = 0; i < 5; i++) step();
    chk1("mr_x_bit4", core_x, 1'b1);
    chkw("mr_t1_partial", t1_word, 8'h0F);
    d0 = n_done;
    res = 1;
    #1 model_reset();
    chk1("mr_busy", busy, 1'b0);
    chk1("mr_core_x", core_x, 1'b0);
    chkw("mr_t1_zero", t1_word, 8'h00);
    chkw("mr_t2_zero", t2_word, 8'h00);
    step();
    step();
    res = 0;
    step();
    chki("mr_no_done", n_done - d0, 0);
    job(1'b1, 8'h96, 4'd8, g2d, bn, rn, xn);
    chki("mr_after_g2d", g2d, 9);
    chkw("mr_after_t1", t1_word, 8'h96);
    chkw("mr_after_t2", t2_word, 8'h69);

    random_phase(500);

    use_real = 1'b1;
    r0 = n_res;
    job(1'b0, 8'h0D, 4'd4, g2d, bn, rn, xn);
    chkw("real_t1", t1_word, 8'h08);
    chkw("real_t2", t2_word, 8'h02);
    chki("real_core_res_pulses", n_res - r0, 1);
    random_phase(500);

    chki("core_res_per_job", n_res, n_jobs);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
